// File: rtl/atu_mp.sv
// Multi-port address translation unit for the LU datapath.
// Holds the logical->physical row permutation and serves NUM_QPORTS lookups
// per cycle. It also applies pivot swaps, single-entry writes and identity
// initialisation, and tracks swap parity and count for the determinant sign.
module atu_mp #(
   parameter int ROW_IDX_W  = 8,
   parameter int NUM_ROWS   = 256,
   parameter int NUM_QPORTS = 2,
   parameter int CNT_W      = 16
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_QPORTS-1:0]           q_req_valid,
   input  logic [NUM_QPORTS*ROW_IDX_W-1:0] q_req_row_logic,
   output logic [NUM_QPORTS-1:0]           q_req_ready,
   output logic [NUM_QPORTS-1:0]           q_resp_valid,
   output logic [NUM_QPORTS*ROW_IDX_W-1:0] q_resp_row_physical,
   output logic [NUM_QPORTS-1:0]           q_resp_err,
   input  logic                            pivot_req_valid,
   input  logic [ROW_IDX_W-1:0]            pivot_row_i,
   input  logic [ROW_IDX_W-1:0]            pivot_row_j,
   output logic                            pivot_req_ready,
   output logic                            pivot_done,
   output logic                            pivot_err,
   input  logic                            cfg_we,
   input  logic [ROW_IDX_W-1:0]            cfg_p_idx,
   input  logic [ROW_IDX_W-1:0]            cfg_p_row_physical,
   output logic                            cfg_ready,
   input  logic                            init_identity,
   output logic                            init_done,
   output logic                            busy,
   output logic                            swap_parity,
   output logic [CNT_W-1:0]                swap_count
);

   typedef enum logic {IDLE, INIT} atuState;

   localparam logic [ROW_IDX_W:0]   NumRowsExt = (ROW_IDX_W+1)'(NUM_ROWS);
   localparam logic [ROW_IDX_W-1:0] LastRow    = ROW_IDX_W'(NUM_ROWS - 1);

   // An index is usable only if it addresses an existing table entry.
   function automatic logic inRange(input logic [ROW_IDX_W-1:0] idx);
      return {1'b0, idx} < NumRowsExt;
   endfunction

   logic [ROW_IDX_W-1:0] pvec [NUM_ROWS];

   atuState              state;
   atuState              stateNext;
   logic [ROW_IDX_W-1:0] initCounter;
   logic                 initPrev;
   logic                 initRise;
   logic                 initStart;
   logic                 initLast;
   logic                 idle;

   logic [ROW_IDX_W-1:0] qRow [NUM_QPORTS];
   logic [NUM_QPORTS-1:0] qAccept;
   logic                 pivotAccept;
   logic                 pivotInRange;
   logic                 pivotSwap;
   logic                 cfgWrite;

   assign initRise = init_identity && !initPrev;

   // Next-state logic: a rising edge on init_identity in IDLE starts the
   // identity sweep; the sweep ends after writing the last row. Edges seen
   // while already sweeping are ignored because only IDLE looks at them.
   always_comb begin
      stateNext = state;
      idle      = 1'b0;
      initStart = 1'b0;
      initLast  = 1'b0;
      case (state)
         IDLE: begin
            idle = 1'b1;
            if (initRise) begin
               stateNext = INIT;
               initStart = 1'b1;
            end
         end
         INIT: begin
            if (initCounter == LastRow) begin
               stateNext = IDLE;
               initLast  = 1'b1;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   assign busy            = (state == INIT);
   assign q_req_ready     = {NUM_QPORTS{idle}};
   assign pivot_req_ready = idle;
   assign cfg_ready       = idle && !pivot_req_valid;

   // Request decode. A pivot outranks a config write because cfg_ready
   // drops whenever a pivot is offered, so the two never collide.
   always_comb begin
      for (int k = 0; k < NUM_QPORTS; k++) begin
         qRow[k] = q_req_row_logic[k*ROW_IDX_W +: ROW_IDX_W];
      end
      qAccept      = q_req_valid & q_req_ready;
      pivotAccept  = pivot_req_valid && idle;
      pivotInRange = inRange(pivot_row_i) && inRange(pivot_row_j);
      pivotSwap    = pivotAccept && pivotInRange && (pivot_row_i != pivot_row_j);
      cfgWrite     = cfg_we && cfg_ready && inRange(cfg_p_idx);
   end

   // State register plus the init sweep counter and the init_identity edge
   // detector. init_done is registered so it pulses the cycle after the
   // last row is written; a reset mid-sweep simply drops back to IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         initPrev    <= 1'b0;
         initCounter <= '0;
         init_done   <= 1'b0;
      end else begin
         state     <= stateNext;
         initPrev  <= init_identity;
         init_done <= initLast;
         if (initStart) begin
            initCounter <= '0;
         end else if (state == INIT) begin
            initCounter <= initCounter + ROW_IDX_W'(1);
         end
      end
   end

   // Permutation storage is deliberately not reset; it only becomes
   // meaningful after an identity sweep or config writes. All updates
   // need the unit idle (or sweeping), so at most one writer is active.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == INIT) begin
            pvec[initCounter] <= initCounter;
         end else if (pivotSwap) begin
            pvec[pivot_row_i] <= pvec[pivot_row_j];
            pvec[pivot_row_j] <= pvec[pivot_row_i];
         end else if (cfgWrite) begin
            pvec[cfg_p_idx] <= cfg_p_row_physical;
         end
      end
   end

   // Pivot completion flags and the swap bookkeeping. Only swaps that
   // actually move two distinct rows count; starting a sweep restarts the
   // bookkeeping because the permutation goes back to identity.
   always_ff @(posedge clk) begin
      if (rst) begin
         pivot_done  <= 1'b0;
         pivot_err   <= 1'b0;
         swap_parity <= 1'b0;
         swap_count  <= '0;
      end else begin
         pivot_done <= pivotAccept;
         pivot_err  <= pivotAccept && !pivotInRange;
         if (initStart) begin
            swap_parity <= 1'b0;
            swap_count  <= '0;
         end else if (pivotSwap) begin
            swap_parity <= ~swap_parity;
            if (swap_count != '1) begin
               swap_count <= swap_count + CNT_W'(1);
            end
         end
      end
   end

   // Query responses, one cycle after accept. The read samples the table
   // before any same-edge swap or write lands, and the data output holds
   // its last value between responses.
   always_ff @(posedge clk) begin
      if (rst) begin
         q_resp_valid        <= '0;
         q_resp_err          <= '0;
         q_resp_row_physical <= '0;
      end else begin
         for (int k = 0; k < NUM_QPORTS; k++) begin
            q_resp_valid[k] <= qAccept[k];
            q_resp_err[k]   <= qAccept[k] && !inRange(qRow[k]);
            if (qAccept[k]) begin
               q_resp_row_physical[k*ROW_IDX_W +: ROW_IDX_W] <=
                  inRange(qRow[k]) ? pvec[qRow[k]] : '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_atu_mp.sv
// Directed testbench for atu_mp. Two instances share every input: a full
// 256-row table and a 200-row table, so out-of-range behaviour can be
// observed on the small one while the large one stays in range.
module tb_atu_mp;

   logic        clk;
   logic        rst;
   logic [1:0]  qReqValid;
   logic [15:0] qReqRow;
   logic        pivotValid;
   logic [7:0]  pivotI;
   logic [7:0]  pivotJ;
   logic        cfgWe;
   logic [7:0]  cfgIdx;
   logic [7:0]  cfgVal;
   logic        initId;

   logic [1:0]  bigReqReady, bigRespValid, bigRespErr;
   logic [15:0] bigRespRow;
   logic        bigPivotReady, bigPivotDone, bigPivotErr, bigCfgReady;
   logic        bigInitDone, bigBusy, bigParity;
   logic [15:0] bigCount;

   logic [1:0]  smlReqReady, smlRespValid, smlRespErr;
   logic [15:0] smlRespRow;
   logic        smlPivotReady, smlPivotDone, smlPivotErr, smlCfgReady;
   logic        smlInitDone, smlBusy, smlParity;
   logic [15:0] smlCount;

   int total = 0;
   int bad   = 0;
   int n;
   int doneCount;

   atu_mp #(.ROW_IDX_W(8), .NUM_ROWS(256), .NUM_QPORTS(2), .CNT_W(16)) dutBig (
      .clk(clk), .rst(rst),
      .q_req_valid(qReqValid), .q_req_row_logic(qReqRow),
      .q_req_ready(bigReqReady), .q_resp_valid(bigRespValid),
      .q_resp_row_physical(bigRespRow), .q_resp_err(bigRespErr),
      .pivot_req_valid(pivotValid), .pivot_row_i(pivotI), .pivot_row_j(pivotJ),
      .pivot_req_ready(bigPivotReady), .pivot_done(bigPivotDone), .pivot_err(bigPivotErr),
      .cfg_we(cfgWe), .cfg_p_idx(cfgIdx), .cfg_p_row_physical(cfgVal),
      .cfg_ready(bigCfgReady), .init_identity(initId), .init_done(bigInitDone),
      .busy(bigBusy), .swap_parity(bigParity), .swap_count(bigCount)
   );

   atu_mp #(.ROW_IDX_W(8), .NUM_ROWS(200), .NUM_QPORTS(2), .CNT_W(16)) dutSml (
      .clk(clk), .rst(rst),
      .q_req_valid(qReqValid), .q_req_row_logic(qReqRow),
      .q_req_ready(smlReqReady), .q_resp_valid(smlRespValid),
      .q_resp_row_physical(smlRespRow), .q_resp_err(smlRespErr),
      .pivot_req_valid(pivotValid), .pivot_row_i(pivotI), .pivot_row_j(pivotJ),
      .pivot_req_ready(smlPivotReady), .pivot_done(smlPivotDone), .pivot_err(smlPivotErr),
      .cfg_we(cfgWe), .cfg_p_idx(cfgIdx), .cfg_p_row_physical(cfgVal),
      .cfg_ready(smlCfgReady), .init_identity(initId), .init_done(smlInitDone),
      .busy(smlBusy), .swap_parity(smlParity), .swap_count(smlCount)
   );

   // Free-running 10-time-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case something never settles.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
      end
   endtask

   // Advance to just after the next rising edge, where outputs are stable.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic driveInputs(input logic [1:0] qv, input logic [7:0] q0, input logic [7:0] q1,
                              input logic pv, input logic [7:0] pi, input logic [7:0] pj,
                              input logic cwe, input logic [7:0] ci, input logic [7:0] cv,
                              input logic ini);
      qReqValid  = qv;
      qReqRow    = {q1, q0};
      pivotValid = pv;
      pivotI     = pi;
      pivotJ     = pj;
      cfgWe      = cwe;
      cfgIdx     = ci;
      cfgVal     = cv;
      initId     = ini;
   endtask

   task automatic clearInputs;
      driveInputs(2'b00, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0, 1'b0);
   endtask

   // Hold one input vector for exactly one clock edge, then return to idle.
   task automatic applyStimulus(input logic [1:0] qv, input logic [7:0] q0, input logic [7:0] q1,
                                input logic pv, input logic [7:0] pi, input logic [7:0] pj,
                                input logic cwe, input logic [7:0] ci, input logic [7:0] cv,
                                input logic ini);
      driveInputs(qv, q0, q1, pv, pi, pj, cwe, ci, cv, ini);
      tick();
      clearInputs();
   endtask

   task automatic query2(input logic [7:0] q0, input logic [7:0] q1);
      applyStimulus(2'b11, q0, q1, 1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0, 1'b0);
   endtask

   task automatic pivot(input logic [7:0] pi, input logic [7:0] pj);
      applyStimulus(2'b00, 8'd0, 8'd0, 1'b1, pi, pj, 1'b0, 8'd0, 8'd0, 1'b0);
   endtask

   task automatic cfgOnly(input logic [7:0] ci, input logic [7:0] cv);
      applyStimulus(2'b00, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0, 1'b1, ci, cv, 1'b0);
   endtask

   // Pulse init for one cycle and count busy cycles and init_done pulses.
   task automatic runInit;
      applyStimulus(2'b00, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0, 1'b1);
      checkOutput("init_busy_start", 32'(bigBusy), 32'd1);
      n = 1;
      doneCount = 0;
      while (bigBusy && n < 1000) begin
         tick();
         if (bigInitDone) doneCount++;
         if (bigBusy) n++;
      end
      checkOutput("init_busy_cycles", 32'(n), 32'd256);
      checkOutput("init_done_count", 32'(doneCount), 32'd1);
      tick();
      checkOutput("init_done_single", 32'(bigInitDone), 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      clearInputs();
      tick();
      tick();

      $display("[TB] reset state");
      checkOutput("rst_q_ready", 32'(bigReqReady), 32'd3);
      checkOutput("rst_pivot_ready", 32'(bigPivotReady), 32'd1);
      checkOutput("rst_cfg_ready", 32'(bigCfgReady), 32'd1);
      checkOutput("rst_busy", 32'(bigBusy), 32'd0);
      checkOutput("rst_resp_valid", 32'(bigRespValid), 32'd0);
      checkOutput("rst_count", 32'(bigCount), 32'd0);
      checkOutput("rst_sml_ready", 32'(smlReqReady), 32'd3);
      rst = 1'b0;

      $display("[TB] T1 identity init and lookups");
      runInit();
      query2(8'd5, 8'd200);
      checkOutput("t1_valid", 32'(bigRespValid), 32'd3);
      checkOutput("t1_rows", 32'(bigRespRow), {16'd0, 8'd200, 8'd5});
      checkOutput("t1_err", 32'(bigRespErr), 32'd0);
      checkOutput("t1_sml_err", 32'(smlRespErr), 32'd2);
      checkOutput("t1_sml_rows", 32'(smlRespRow), {16'd0, 8'd0, 8'd5});
      tick();
      checkOutput("t1_valid_drop", 32'(bigRespValid), 32'd0);
      checkOutput("t1_rows_hold", 32'(bigRespRow), {16'd0, 8'd200, 8'd5});

      $display("[TB] T2 pivot swaps");
      pivot(8'd3, 8'd7);
      checkOutput("t2_done", 32'(bigPivotDone), 32'd1);
      checkOutput("t2_err", 32'(bigPivotErr), 32'd0);
      checkOutput("t2_parity", 32'(bigParity), 32'd1);
      checkOutput("t2_count", 32'(bigCount), 32'd1);
      query2(8'd3, 8'd7);
      checkOutput("t2_rows", 32'(bigRespRow), {16'd0, 8'd3, 8'd7});
      pivot(8'd4, 8'd4);
      checkOutput("t2_same_done", 32'(bigPivotDone), 32'd1);
      checkOutput("t2_same_parity", 32'(bigParity), 32'd1);
      checkOutput("t2_same_count", 32'(bigCount), 32'd1);

      $display("[TB] T3 read before swap");
      applyStimulus(2'b01, 8'd0, 8'd0, 1'b1, 8'd0, 8'd1, 1'b0, 8'd0, 8'd0, 1'b0);
      checkOutput("t3_valid", 32'(bigRespValid), 32'd1);
      checkOutput("t3_pre_swap", 32'(bigRespRow[7:0]), 32'd0);
      query2(8'd0, 8'd1);
      checkOutput("t3_post_swap", 32'(bigRespRow), {16'd0, 8'd0, 8'd1});
      checkOutput("t3_count", 32'(bigCount), 32'd2);
      checkOutput("t3_parity", 32'(bigParity), 32'd0);

      $display("[TB] T4 pivot priority over config");
      driveInputs(2'b00, 8'd0, 8'd0, 1'b1, 8'd10, 8'd10, 1'b1, 8'd2, 8'd9, 1'b0);
      #1;
      checkOutput("t4_cfg_ready_low", 32'(bigCfgReady), 32'd0);
      tick();
      clearInputs();
      checkOutput("t4_pivot_done", 32'(bigPivotDone), 32'd1);
      query2(8'd2, 8'd2);
      checkOutput("t4_cfg_blocked", 32'(bigRespRow), {16'd0, 8'd2, 8'd2});
      cfgOnly(8'd2, 8'd9);
      query2(8'd2, 8'd0);
      checkOutput("t4_cfg_written", 32'(bigRespRow), {16'd0, 8'd1, 8'd9});
      checkOutput("t4_count_kept", 32'(bigCount), 32'd2);

      $display("[TB] T6 reset aborts init");
      applyStimulus(2'b00, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0, 1'b1);
      repeat (99) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("t6_busy_abort", 32'(bigBusy), 32'd0);
      doneCount = 0;
      for (int c = 0; c < 300; c++) begin
         tick();
         if (bigInitDone) doneCount++;
      end
      checkOutput("t6_no_done", 32'(doneCount), 32'd0);
      pivot(8'd250, 8'd251);
      checkOutput("t6_count_pre", 32'(bigCount), 32'd1);
      cfgOnly(8'd240, 8'd17);
      query2(8'd250, 8'd240);
      checkOutput("t6_rows_pre", 32'(bigRespRow), {16'd0, 8'd17, 8'd251});
      runInit();
      checkOutput("t6_count_clear", 32'(bigCount), 32'd0);
      checkOutput("t6_parity_clear", 32'(bigParity), 32'd0);
      query2(8'd250, 8'd240);
      checkOutput("t6_identity_a", 32'(bigRespRow), {16'd0, 8'd240, 8'd250});
      query2(8'd251, 8'd100);
      checkOutput("t6_identity_b", 32'(bigRespRow), {16'd0, 8'd100, 8'd251});

      $display("[TB] T5 out-of-range on 200-row table");
      query2(8'd250, 8'd1);
      checkOutput("t5_sml_valid", 32'(smlRespValid), 32'd3);
      checkOutput("t5_sml_err", 32'(smlRespErr), 32'd1);
      checkOutput("t5_sml_rows", 32'(smlRespRow), {16'd0, 8'd1, 8'd0});
      checkOutput("t5_big_rows", 32'(bigRespRow), {16'd0, 8'd1, 8'd250});
      checkOutput("t5_big_err", 32'(bigRespErr), 32'd0);
      pivot(8'd1, 8'd250);
      checkOutput("t5_sml_done", 32'(smlPivotDone), 32'd1);
      checkOutput("t5_sml_perr", 32'(smlPivotErr), 32'd1);
      checkOutput("t5_sml_parity", 32'(smlParity), 32'd0);
      checkOutput("t5_sml_count", 32'(smlCount), 32'd0);
      checkOutput("t5_big_perr", 32'(bigPivotErr), 32'd0);
      checkOutput("t5_big_parity", 32'(bigParity), 32'd1);
      query2(8'd1, 8'd250);
      checkOutput("t5_sml_unchanged", 32'(smlRespRow), {16'd0, 8'd0, 8'd1});
      checkOutput("t5_sml_err2", 32'(smlRespErr), 32'd2);
      checkOutput("t5_big_swapped", 32'(bigRespRow), {16'd0, 8'd1, 8'd250});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
